// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and counter sizing for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } pll_sup_state_t;

    // Width of the shared down-counter: clog2 of the largest cycle count.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    localparam int CNT_WIDTH = cnt_width(16, 1024, 65536);

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// PLL-side and status signals of the lock supervisor.
interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
);
    logic             locked_in;
    logic             clr_err;
    logic             pll_rst;
    logic             sys_reset_n;
    logic             lock_ok;
    logic             timeout_err;
    logic [CNT_W-1:0] relock_count;

    modport master (
        input  locked_in, clr_err,
        output pll_rst, sys_reset_n, lock_ok, timeout_err, relock_count
    );

    modport slave (
        output locked_in, clr_err,
        input  pll_rst, sys_reset_n, lock_ok, timeout_err, relock_count
    );
endinterface

// File: rtl/pll_lock_supervisor_bit_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-low clear.
module bit_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencing, lock qualification and system reset release.
// PLL_SUP_AUTO_RELOCK_EN: re-pulse the PLL reset on lock loss and timeout.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES        = 16,
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int RELOCK_TIMEOUT_CYCLES = 65536,
    parameter int CNT_W                 = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    pll_lock_supervisor_if.master bus
);
    localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                  RELOCK_TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LD_RST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] LD_STB = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] LD_TO  = CW'(RELOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RC_MAX = '1;

    logic             w_lk_s;
    pll_sup_state_t   r_state;
    pll_sup_state_t   w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             r_pll_rst;
    logic             r_sys_rst_n;
    logic             r_timeout_err;
    logic             w_err_nxt;
    logic             w_to_set;
    logic             w_lock_lost;
    logic [CNT_W-1:0] r_relock_cnt;
    logic [CNT_W-1:0] w_relock_nxt;

    bit_sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .i_d   (bus.locked_in),
        .o_q   (w_lk_s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RESET_PLL;
            r_cnt         <= LD_RST;
            r_pll_rst     <= 1'b1;
            r_sys_rst_n   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_relock_cnt  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pll_rst     <= (w_state_nxt == RESET_PLL);
            r_sys_rst_n   <= (w_state_nxt == RUN);
            r_timeout_err <= w_err_nxt;
            r_relock_cnt  <= w_relock_nxt;
        end
    end

    // The counter reloads on every entry, so it always counts time-in-state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_to_set    = 1'b0;
        w_lock_lost = 1'b0;
        case (r_state)
            RESET_PLL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TO;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (w_lk_s) begin
                    w_state_nxt = STABILIZE;
                    w_cnt_nxt   = LD_STB;
                end else if (r_cnt == '0) begin
                    w_to_set = 1'b1;
`ifdef PLL_SUP_AUTO_RELOCK_EN
                    w_state_nxt = RESET_PLL;
                    w_cnt_nxt   = LD_RST;
`else
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TO;
`endif
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            STABILIZE: begin
                if (!w_lk_s) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TO;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RUN: begin
                if (!w_lk_s) begin
                    w_lock_lost = 1'b1;
`ifdef PLL_SUP_AUTO_RELOCK_EN
                    w_state_nxt = RESET_PLL;
                    w_cnt_nxt   = LD_RST;
`else
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = LD_TO;
`endif
                end
            end
            default: begin
                w_state_nxt = RESET_PLL;
                w_cnt_nxt   = LD_RST;
            end
        endcase
    end

    always_comb begin
        w_err_nxt    = w_to_set | (r_timeout_err & ~bus.clr_err);
        w_relock_nxt = r_relock_cnt;
        if (w_lock_lost && (r_relock_cnt != RC_MAX))
            w_relock_nxt = r_relock_cnt + 1'b1;
    end

    assign bus.pll_rst      = r_pll_rst;
    assign bus.sys_reset_n  = r_sys_rst_n;
    assign bus.lock_ok      = r_sys_rst_n;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.relock_count = r_relock_cnt;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: vector table, directed corners, random vs model.
module tb_pll_lock_supervisor;
    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;
    localparam int CW    = 2;
    localparam int RC_MAX = (1 << CW) - 1;
`ifdef PLL_SUP_AUTO_RELOCK_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef enum int {M_RST, M_WAIT, M_STB, M_RUN} mphase_t;

    typedef struct {
        bit         rn;
        bit         lk;
        bit         clr;
        bit         e_pll;
        bit         e_sys;
        bit         e_err;
        logic [1:0] e_rc;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    pll_lock_supervisor_if #(.CNT_W(CW)) ifc ();

    pll_lock_supervisor #(
        .PLL_RST_CYCLES        (P_RST),
        .LOCK_STABLE_CYCLES    (P_STB),
        .RELOCK_TIMEOUT_CYCLES (P_TO),
        .CNT_W                 (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc.master)
    );

    always #10 clk = ~clk;

    // Reference model: phase plus entry timestamp, lock seen two edges late.
    mphase_t m_phase;
    int      m_now;
    int      m_entry;
    int      m_rc;
    bit      m_err;
    bit      m_s0;
    bit      m_s1;

    function automatic void m_reset();
        m_phase = M_RST;
        m_now   = 0;
        m_entry = 0;
        m_rc    = 0;
        m_err   = 1'b0;
        m_s0    = 1'b0;
        m_s1    = 1'b0;
    endfunction

    function automatic void m_enter(mphase_t p);
        m_phase = p;
        m_entry = m_now;
    endfunction

    function automatic void m_edge(bit lk, bit clr);
        bit lks;
        bit set;
        int el;
        lks  = m_s1;
        m_s1 = m_s0;
        m_s0 = lk;
        m_now++;
        el  = m_now - m_entry;
        set = 1'b0;
        case (m_phase)
            M_RST:  if (el >= P_RST) m_enter(M_WAIT);
            M_WAIT: begin
                if (lks) m_enter(M_STB);
                else if (el >= P_TO) begin
                    set = 1'b1;
                    m_enter(AUTO ? M_RST : M_WAIT);
                end
            end
            M_STB: begin
                if (!lks) m_enter(M_WAIT);
                else if (el >= P_STB) m_enter(M_RUN);
            end
            default: begin
                if (!lks) begin
                    if (m_rc < RC_MAX) m_rc++;
                    m_enter(AUTO ? M_RST : M_WAIT);
                end
            end
        endcase
        m_err = set | (m_err & !clr);
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp,
                     $time);
        end
    endtask

    task automatic step(input bit rn, input bit lk, input bit clr);
        logic [5:0] got;
        logic [5:0] exp;
        reset_n       = rn;
        ifc.locked_in = lk;
        ifc.clr_err   = clr;
        if (!rn) m_reset();
        @(posedge clk);
        if (rn) m_edge(lk, clr);
        @(negedge clk);
        got = {ifc.pll_rst, ifc.sys_reset_n, ifc.lock_ok, ifc.timeout_err,
               ifc.relock_count};
        exp = {m_phase == M_RST, m_phase == M_RUN, m_phase == M_RUN, m_err,
               2'(m_rc)};
        chk("model{pll,sys,ok,err,rc}", 32'(got), 32'(exp));
    endtask

    task automatic hold(input bit lk, input int n);
        for (int i = 0; i < n; i++) step(1'b1, lk, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[21];
        bit         saw_sys;
        int         t_second;
        logic [1:0] rc_exp[4];

        reset_n       = 1'b0;
        ifc.locked_in = 1'b0;
        ifc.clr_err   = 1'b0;
        m_reset();

        // Reset release, lock 5 cycles after pll_rst falls, RUN 8 edges later.
        tbl[0] = '{rn: 1'b0, lk: 1'b0, clr: 1'b0, e_pll: 1'b1, e_sys: 1'b0,
                   e_err: 1'b0, e_rc: 2'd0};
        for (int k = 1; k < 21; k++)
            tbl[k] = '{rn: 1'b1, lk: (k >= 9), clr: 1'b0, e_pll: (k < 4),
                       e_sys: (k >= 19), e_err: 1'b0, e_rc: 2'd0};

        @(negedge clk);
        for (int i = 0; i < 21; i++) begin
            step(tbl[i].rn, tbl[i].lk, tbl[i].clr);
            chk($sformatf("tbl%0d_pll", i), 32'(ifc.pll_rst), 32'(tbl[i].e_pll));
            chk($sformatf("tbl%0d_sys", i), 32'(ifc.sys_reset_n),
                32'(tbl[i].e_sys));
            chk($sformatf("tbl%0d_ok", i), 32'(ifc.lock_ok), 32'(tbl[i].e_sys));
            chk($sformatf("tbl%0d_err", i), 32'(ifc.timeout_err),
                32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_rc", i), 32'(ifc.relock_count),
                32'(tbl[i].e_rc));
        end

        // Lock glitch during STABILIZE: back to WAIT, no release, no count.
        step(1'b0, 1'b0, 1'b0);
        saw_sys = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step(1'b1, (k >= 9 && k <= 12) || k >= 16, 1'b0);
            saw_sys |= ifc.sys_reset_n;
        end
        chk("stb_glitch_sys", 32'(saw_sys), 32'd0);
        chk("stb_glitch_rc", 32'(ifc.relock_count), 32'd0);
        hold(1'b1, 12);
        chk("stb_glitch_run", 32'(ifc.sys_reset_n), 32'd1);

        // Lock never arrives: timeout at WAIT edge 32, then clear.
        step(1'b0, 1'b0, 1'b0);
        hold(1'b0, 35);
        chk("to_before", 32'(ifc.timeout_err), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("to_err", 32'(ifc.timeout_err), 32'd1);
        chk("to_pll", 32'(ifc.pll_rst), 32'(AUTO));
        for (int k = 37; k <= 39; k++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("to_pll_e%0d", k), 32'(ifc.pll_rst), 32'(AUTO));
        end
        step(1'b1, 1'b0, 1'b0);
        chk("to_pll_e40", 32'(ifc.pll_rst), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("clr_err", 32'(ifc.timeout_err), 32'd0);
        t_second = AUTO ? 36 + P_RST + P_TO : 36 + P_TO;
        for (int k = 42; k < t_second; k++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(ifc.timeout_err), 32'd1);

        // Four lock losses in RUN: count saturates, release drops 2 edges late.
        rc_exp = '{2'd1, 2'd2, 2'd3, 2'd3};
        step(1'b0, 1'b0, 1'b0);
        hold(1'b1, 20);
        chk("relock_run0", 32'(ifc.sys_reset_n), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("loss%0d_e0", i), 32'(ifc.sys_reset_n), 32'd1);
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("loss%0d_e1", i), 32'(ifc.sys_reset_n), 32'd1);
            step(1'b1, 1'b0, 1'b0);
            chk($sformatf("loss%0d_e2", i), 32'(ifc.sys_reset_n), 32'd0);
            chk($sformatf("loss%0d_pll", i), 32'(ifc.pll_rst), 32'(AUTO));
            chk($sformatf("loss%0d_rc", i), 32'(ifc.relock_count),
                32'(rc_exp[i]));
            hold(1'b1, 30);
            chk($sformatf("loss%0d_rerun", i), 32'(ifc.sys_reset_n), 32'd1);
        end

        // Asynchronous reset mid-RUN, observed before any clock edge.
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_pll", 32'(ifc.pll_rst), 32'd1);
        chk("async_sys", 32'(ifc.sys_reset_n), 32'd0);
        chk("async_ok", 32'(ifc.lock_ok), 32'd0);
        chk("async_rc", 32'(ifc.relock_count), 32'd0);
        chk("async_err", 32'(ifc.timeout_err), 32'd0);
        m_reset();
        @(negedge clk);
        step(1'b0, 1'b1, 1'b0);

        // Random lock bursts, clears and occasional resets against the model.
        for (int b = 0; b < 80; b++) begin
            bit lk;
            int len;
            lk  = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 45));
            for (int j = 0; j < len; j++)
                step($urandom_range(0, 299) != 0, lk,
                     $urandom_range(0, 7) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the system PLL from its 50 MHz reference-clock domain. It issues the PLL reset, watches the asynchronous `locked` indication, and qualifies lock over a stability window. It releases the system reset only after lock is stable, and automatically re-locks the PLL when lock is lost. It sits between the board clock/reset input and the PLL and system reset fabric, and is the consumer of the PLL's `locked` output and the driver of its `rst` input.

## Interface
- `PLL_RST_CYCLES`, 16: clk cycles `pll_rst` is held high per reset pulse (≥2).
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required before release (≥2).
- `RELOCK_TIMEOUT_CYCLES`, 65536: maximum cycles waiting for lock before re-pulsing the PLL reset (≥2).
- `CNT_W`, 8: width of the relock event counter.

Ports:
- `clk` in 1: reference clock, 50 MHz, free-running and independent of the PLL.
- `reset_n` in 1: asynchronous active-low reset. Assertion is asynchronous; deassertion is synchronized externally.
- `locked_in` in 1: PLL `locked`, asynchronous to `clk`.
- `clr_err` in 1: synchronous pulse that clears `timeout_err`.
- `pll_rst` out 1: active-high reset to the PLL.
- `sys_reset_n` out 1: active-low system reset; high only when lock is qualified.
- `lock_ok` out 1: status, equal to `sys_reset_n`.
- `timeout_err` out 1: sticky flag, set when a lock wait timed out.
- `relock_count` out CNT_W: number of lock losses seen in RUN, saturating.

## Operation
- `locked_in` passes through a 2-flop synchronizer to produce `lk_s`. Only `lk_s` is used internally.
- There are four states. One shared down-counter serves all timed states and reloads on every state entry.
  - RESET_PLL: `pll_rst`=1. Lasts exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK. `lk_s` is ignored.
  - WAIT_LOCK: `pll_rst`=0.
    - If `lk_s`=1, go to STABILIZE.
    - Otherwise, after RELOCK_TIMEOUT_CYCLES cycles without lock, set `timeout_err` and go to RESET_PLL.
  - STABILIZE:
    - If `lk_s` drops, go to WAIT_LOCK and reload the timeout counter. `relock_count` is unchanged.
    - After LOCK_STABLE_CYCLES consecutive cycles with `lk_s`=1, go to RUN.
  - RUN: `sys_reset_n`=1 and `lock_ok`=1. If `lk_s`=0, go to RESET_PLL and increment `relock_count`, saturating at 2^CNT_W−1.
- All outputs are registered Moore decodes of the state. `sys_reset_n` is high only in RUN.
- `timeout_err`:
  - Set by a timeout and cleared by `clr_err`.
  - If set and clear occur in the same cycle, set wins.
  - `clr_err` has no effect on the state machine.
- `reset_n` asserted at any point, including mid-RUN:
  - State immediately returns to RESET_PLL.
  - The counter is reloaded, `relock_count` and `timeout_err` clear, and the synchronizer clears.

## Timing
- Reset values: `pll_rst`=1, `sys_reset_n`=0, `lock_ok`=0, `timeout_err`=0, `relock_count`=0, state=RESET_PLL.
- After `reset_n` rises, `pll_rst` stays high for PLL_RST_CYCLES rising edges, then goes low.
- From a `locked_in` rise (meeting setup at edge N) to STABILIZE entry: edge N+2.
- From STABILIZE entry to `sys_reset_n`=1: LOCK_STABLE_CYCLES edges.
- From a `locked_in` fall in RUN (at edge N) to `sys_reset_n`=0 and `pll_rst`=1: edge N+2.
  - `relock_count` updates on that same edge.
- A lock pulse shorter than 2 cycles may be missed. This is acceptable; the PLL guarantees a longer pulse.
- When the timeout expires, the `timeout_err` set and the RESET_PLL entry occur on the same edge.

## Configuration
- `PLL_SUP_AUTO_RELOCK_EN`
  - Defined: behaviour as above, with automatic PLL reset on loss of lock and on timeout.
  - Undefined:
    - Loss of lock in RUN goes to WAIT_LOCK, not RESET_PLL. `relock_count` still increments.
    - A WAIT_LOCK timeout sets `timeout_err` and stays in WAIT_LOCK with the counter reloaded.
    - `pll_rst` is pulsed only after `reset_n`.

## Structure
- Package `pll_sup_pkg` holds:
  - `pll_sup_state_t`, an enum of RESET_PLL, WAIT_LOCK, STABILIZE and RUN.
  - Localparam counter width derived as $clog2 of the maximum of the three cycle parameters.
- Sub-module `bit_sync_2ff`: the 2-flop synchronizer with async active-low clear, reused for `locked_in`.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, RELOCK_TIMEOUT_CYCLES=32, CNT_W=2.
- Reset release with `locked_in`=0 → `pll_rst` high for exactly 4 edges, then low; `sys_reset_n` stays 0.
- Raise `locked_in` 5 cycles after `pll_rst` falls and hold it → STABILIZE 2 edges later; `sys_reset_n`=1 exactly 8 edges after that.
- Drop `locked_in` for 3 cycles during STABILIZE → returns to WAIT_LOCK; `sys_reset_n` never rises; `relock_count` stays 0.
- Never assert lock → at edge 32 of WAIT_LOCK, `timeout_err`=1 and `pll_rst` re-pulses for 4 cycles. Pulse `clr_err` afterward → `timeout_err`=0.
- In RUN, drop lock 4 times with full relock between → `relock_count` reads 1, 2, 3, 3 (saturated). Each `sys_reset_n` fall is 2 edges after the `locked_in` fall.
- Assert `reset_n` asynchronously mid-RUN → `sys_reset_n`=0 and `pll_rst`=1 immediately, with no clock edge; the counters clear.
